// File: rtl/melody_pkg.sv
// melody_pkg: key codes, FSM states and tone half-period table for melody_player
package melody_pkg;
  localparam logic [7:0] KEY_REST = 8'h00;
  localparam logic [7:0] KEY_END = 8'hFF;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;
  function automatic logic [16:0] tone_half(input logic [2:0] idx);
    case (idx)
      3'd0: return 17'd95556;
      3'd1: return 17'd85131;
      3'd2: return 17'd75843;
      3'd3: return 17'd71586;
      3'd4: return 17'd63776;
      3'd5: return 17'd56818;
      3'd6: return 17'd50619;
      default: return 17'd47778;
    endcase
  endfunction
endpackage

// File: rtl/melody_tone_gen.sv
// tone_gen: square wave toggling every half_period cycles while enabled
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [16:0] half_period,
  output logic        sq
);
  logic [16:0] cnt;
  always_ff @(posedge clk)
    if (!rst || !en) begin
      cnt <= '0;
      sq <= 1'b0;
    end else if (cnt == half_period - 17'd1) begin
      cnt <= '0;
      sq <= ~sq;
    end else
      cnt <= cnt + 17'd1;
endmodule

// File: rtl/melody_player.sv
// melody_player: walks the note memory, decodes key codes and drives the piezo
module melody_player
  import melody_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int NOTE_TICKS = 12_500_000,
  parameter int DIV_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              piezo
);
  localparam logic [ADDR_W:0] LAST_NOTE = (ADDR_W+1)'((1 << ADDR_W) - 1);
  state_t state, state_d;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] note_cnt;
  logic [31:0] dur_cnt;
  logic [16:0] half, hp;
  logic [2:0] idx;
  logic tone, last, tone_en;
  always_comb begin
    idx = '0;
    for (int k = 0; k < 8; k++) if (mem_rdata[k]) idx = 3'(k);
    hp = tone_half(idx) >> DIV_SHIFT;
    last = dur_cnt == 32'(NOTE_TICKS - 1);
    state_d = state;
    case (state)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: state_d = LOAD;
      LOAD: state_d = mem_rdata == KEY_END ? DONE : PLAY;
      PLAY: state_d = !last ? PLAY : note_cnt == LAST_NOTE ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
    // dropping enable on the final PLAY cycle or on stop zeroes the piezo at that edge
    tone_en = tone && state == PLAY && state_d == PLAY;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      note_cnt <= '0;
      dur_cnt <= '0;
      half <= '0;
      tone <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && state_d == FETCH) begin
        addr <= start_addr;
        note_cnt <= '0;
      end
      if (state == LOAD) begin
        dur_cnt <= '0;
        tone <= mem_rdata != KEY_REST && $onehot(mem_rdata);
        half <= hp == '0 ? 17'd1 : hp;
      end
      if (state == PLAY) begin
        dur_cnt <= dur_cnt + 32'd1;
        if (last) begin
          addr <= addr + 1'b1;
          note_cnt <= note_cnt + 1'b1;
        end
      end
    end
  assign mem_rd_en = state == FETCH;
  assign mem_addr = addr;
  assign busy = state != IDLE;
  assign done = state == DONE;
  tone_gen u_tone (
    .clk(clk),
    .rst(rst),
    .en(tone_en),
    .half_period(half),
    .sq(piezo)
  );
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: scoreboard bench; expected read/piezo/done events are queued, a monitor pops them
module tb_melody_player;
  localparam int NT = 64;
  localparam int SH = 12;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
  logic [5:0] start_addr = '0;
  logic mem_rd_en, busy, done, piezo;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem [64];
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit mon_on = 0;
  logic pz_prev = 1'b0;
  int tbl [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
  typedef struct {int kind; int val; int cyc;} ev_t;
  ev_t sb [$];

  melody_player #(.ADDR_W(6), .NOTE_TICKS(NT), .DIV_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .start_addr(start_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .piezo(piezo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  function void push(int k, int v, int c);
    sb.push_back('{k, v, c});
  endfunction

  function void check_ev(int k, int v, int c);
    ev_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event: got kind=%0d val=%0d cyc=%0d, required none", k, v, c);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.val != v || e.cyc != c) begin
      n_fail++;
      $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
               k, v, c, e.kind, e.val, e.cyc);
    end
  endfunction

  function void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endfunction

  // kinds: 0 piezo edge, 1 memory read, 2 done
  always @(negedge clk) if (mon_on) begin
    if (piezo !== pz_prev) begin
      check_ev(0, int'(piezo), cyc);
      pz_prev = piezo;
    end
    if (mem_rd_en) check_ev(1, int'(mem_addr), cyc);
    if (done) check_ev(2, 0, cyc);
  end

  function automatic int half_of(logic [7:0] code);
    int i = 0;
    int h;
    for (int b = 0; b < 8; b++) if (code[b]) i = b;
    h = tbl[i] >> SH;
    return h < 1 ? 1 : h;
  endfunction

  function automatic void expect_song(int s, int a0);
    int t = s + 1;
    int a = a0;
    int h;
    bit lvl;
    for (int n = 0; n < 64; n++) begin
      push(1, a, t);
      if (mem[a] == 8'hFF) begin
        push(2, 0, t + 2);
        return;
      end
      if ($onehot(mem[a])) begin
        h = half_of(mem[a]);
        lvl = 0;
        for (int k = h; k <= NT - 1; k += h) begin
          lvl = ~lvl;
          push(0, int'(lvl), t + 2 + k);
        end
        if (lvl) push(0, 0, t + NT + 2);
      end
      t += NT + 2;
      a = (a + 1) % 64;
    end
    push(2, 0, t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic play(input int a, output int s);
    start_addr = 6'(a);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int idle);
    int k = 0;
    while (sb.size() != 0 && k < 6000) begin
      tick();
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
    repeat (idle) tick();
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[5] = 8'h20;
    mem[6] = 8'h00;
    mem[7] = 8'hFF;
    repeat (3) tick();
    chk("rst_piezo", int'(piezo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    rst = 1'b1;
    pz_prev = 1'b0;
    mon_on = 1;
    tick();

    play(5, s);
    expect_song(s, 5);
    wait_drain(4);

    play(5, s);
    push(1, 5, s + 1);
    push(0, 1, s + 16);
    push(0, 0, s + 29);
    go_to(s + 33);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_piezo", int'(piezo), 0);
    chk("stop_rd_en", int'(mem_rd_en), 0);
    wait_drain(150);

    start = 1'b1;
    stop = 1'b1;
    start_addr = 6'd5;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    wait_drain(20);

    mem[10] = 8'h03;
    mem[11] = 8'hFF;
    play(10, s);
    expect_song(s, 10);
    go_to(s + 20);
    start_addr = 6'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_addr", int'(mem_addr), 10);
    wait_drain(4);

    play(5, s);
    push(1, 5, s + 1);
    push(0, 1, s + 16);
    go_to(s + 20);
    rst = 1'b0;
    sb.delete();
    push(0, 0, s + 21);
    tick();
    rst = 1'b1;
    chk("midrst_piezo", int'(piezo), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd_en", int'(mem_rd_en), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    wait_drain(2);
    play(6, s);
    expect_song(s, 6);
    wait_drain(4);

    for (int i = 0; i < 64; i++) mem[i] = 8'h01;
    play(62, s);
    expect_song(s, 62);
    wait_drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Playback engine for the piezo recorder. The recorder writes one 8-bit key code per slot into the 6-bit-addressed note memory; this block reads that memory back and plays it.
- It walks the note memory from a start slot, decodes each key code to a tone, and drives the piezo with a square wave for a fixed note duration.
- It stops at an end marker, after a full pass of the memory, or on an explicit stop request.
- It sits beside the recorder and shares the note memory through a dedicated read port.

Parameters:
- ADDR_W, 6, note memory address width; the memory has 2**ADDR_W slots.
- NOTE_TICKS, 12_500_000, clock cycles each note or rest is held (0.25 s at 50 MHz); must be at least 2.
- DIV_SHIFT, 0, right shift applied to every tone half-period table entry. Benches set it nonzero to shorten simulation.

Ports:
- clk, in, 1, system clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-low reset.
- start, in, 1, single-cycle request to begin playback at start_addr; ignored while busy.
- stop, in, 1, single-cycle abort request.
- start_addr, in, ADDR_W, first slot to play.
- mem_rd_en, out, 1, note memory read strobe.
- mem_addr, out, ADDR_W, note memory read address.
- mem_rdata, in, 8, key code; valid in the cycle after mem_rd_en (synchronous RAM, latency 1).
- busy, out, 1, high whenever the FSM is not in IDLE.
- done, out, 1, one-cycle pulse on natural end of the song.
- piezo, out, 1, square-wave drive to the piezo.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE.
  - piezo, busy, done and mem_rd_en are 0; mem_addr is 0; all counters are 0.
  - Reset is honoured mid-playback; it overrides start and stop.
- Key code decode:
  - 8'hFF is the end marker.
  - 8'h00 is a rest.
  - Exactly one bit i set means tone i, where i=0..7 maps to C4 D4 E4 F4 G4 A4 B4 C5.
  - Any other multi-bit code is played as a rest.
- Half-period table (50 MHz clock): 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778. The value used is table[i] >> DIV_SHIFT, with a minimum of 1.
- FSM states:
  - IDLE: start=1 and stop=0 -> FETCH, addr <= start_addr, note_cnt <= 0.
  - FETCH: one cycle; mem_rd_en=1, mem_addr=addr -> LOAD.
  - LOAD: capture mem_rdata.
    - End marker -> DONE.
    - Otherwise load the tone or rest, reset the duration and half-period counters, set piezo to 0 -> PLAY.
  - PLAY: held for NOTE_TICKS cycles.
    - For a tone, piezo toggles each time the half-period counter reaches half_period-1; the counter then restarts.
    - For a rest, piezo stays 0.
    - At the end of the duration: piezo <= 0, addr <= addr+1 (wraps modulo 2**ADDR_W), note_cnt <= note_cnt+1.
    - If note_cnt+1 == 2**ADDR_W -> DONE (full pass with no marker); else -> FETCH.
  - DONE: done=1 for one cycle, piezo=0 -> IDLE.
- busy is 1 in FETCH, LOAD, PLAY and DONE.
- Note period: NOTE_TICKS+2 cycles (FETCH + LOAD + PLAY).
- Latency: from start sampled, mem_rd_en is asserted in the next cycle.
- stop in any non-IDLE state: next cycle the FSM is in IDLE with piezo=0 and mem_rd_en=0. No done pulse is generated. stop takes priority over the state's own transition.
- start while busy is ignored. start and stop together in IDLE: stop wins and the block stays in IDLE.
- start in the same cycle that DONE returns to IDLE is ignored; it must be reissued.

Decomposition:
- Package melody_pkg:
  - Key-code constants KEY_REST=8'h00 and KEY_END=8'hFF.
  - FSM state enum {IDLE, FETCH, LOAD, PLAY, DONE}.
  - Half-period table function tone_half(idx) returning a 17-bit value.
- One sub-module, tone_gen:
  - Inputs: clk, rst, en, half_period; output: sq.
  - Owns the half-period counter and the toggle flop.
  - sq clears when en=0.

Test Plan:
- Setup for all scenarios: DIV_SHIFT=12, NOTE_TICKS=64. Memory model: slot5=8'h20, slot6=8'h00, slot7=8'hFF. This gives an A4 half-period of 13.
- Basic playback: start_addr=5, pulse start.
  - mem_rd_en pulses at slots 5, 6, 7, each 66 cycles apart.
  - piezo toggles every 13 cycles during slot 5 and is 0 during slot 6.
  - done pulses once, 1 cycle after the LOAD of slot 7; busy then falls.
- Abort: stop pulsed at cycle 30 of the first PLAY.
  - Next cycle: IDLE, piezo=0, busy=0.
  - No done pulse and no further mem_rd_en.
- Wrap and full pass: memory filled with 8'h01 and no end marker, start_addr=62.
  - Addresses run 62, 63, 0, 1, … for exactly 64 reads.
  - done pulses after the 64th note.
  - C4 half-period is 23 cycles.
- Illegal code and start-while-busy:
  - Slot value 8'h03 plays as a rest (piezo stays 0).
  - A second start during PLAY changes neither mem_addr nor timing.
- Reset mid-play: rst=0 for one cycle during a tone.
  - All outputs are 0 on the next edge.
  - A fresh start then replays from the new start_addr.
